// File: rtl/prog_delay_rg.sv
// Programmable delay line with refill gating.
// Every input sample {din, din_frame} is written into a circular buffer whose
// write pointer advances on every clock. The output is read D entries behind
// the write pointer. After reset or a delay change the line is marked invalid
// until D fresh samples have been written, so stale contents never appear valid.
module prog_delay_rg #(
    parameter int W    = 6,
    parameter int DMAX = 128,
    parameter int DDEF = 100,
    localparam int AW  = $clog2(DMAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  din,
    input  logic          din_frame,
    input  logic [AW-1:0] cfg_delay,
    input  logic          cfg_load,
    output logic          cfg_busy,
    output logic [AW-1:0] cur_delay,
    output logic [W-1:0]  dout,
    output logic          dout_frame,
    output logic          dout_valid
);

    // Power-of-two depth of at least DMAX+1 entries: pointer arithmetic wraps
    // naturally in AW bits, and the read slot never collides with the slot
    // being written in the same cycle.
    localparam int DEPTH = 1 << AW;

    localparam logic [AW-1:0] DMAX_C = AW'(DMAX);
    localparam int DDEF_I = (DDEF < 1) ? 1 : ((DDEF > DMAX) ? DMAX : DDEF);
    localparam logic [AW-1:0] DDEF_C = AW'(DDEF_I);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] fill_q;
    logic [AW-1:0] cur_delay_q;
    logic [AW-1:0] rd_addr_d;
    logic [AW-1:0] load_delay_d;
    state_t        state_q;
    logic [W-1:0]  dout_q;
    logic          dout_frame_q;
    logic          dout_valid_q;
    logic          cfg_busy_q;

    // Requested delay limited to 1..DMAX; zero means "shortest possible".
    function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] req);
        if (req == '0) begin
            return AW'(1);
        end else if (req > DMAX_C) begin
            return DMAX_C;
        end else begin
            return req;
        end
    endfunction

    // Read slot trails the write slot by the active delay; clamp the request.
    always_comb begin
        rd_addr_d    = wp_q - cur_delay_q;
        load_delay_d = clamp_delay(cfg_delay);
    end

    // Sample storage: written every cycle, never cleared.
    always_ff @(posedge clk) begin
        mem_q[wp_q] <= {din, din_frame};
    end

    // Write pointer advances every cycle, independent of FILL/RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
        end else begin
            wp_q <= wp_q + AW'(1);
        end
    end

    // Fill/run control with registered outputs; the buffer read is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            cur_delay_q  <= DDEF_C;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_frame_q <= 1'b0;
            dout_valid_q <= 1'b0;
            cfg_busy_q   <= 1'b1;
        end else if (cfg_load) begin
            // Any load, even of the same delay, restarts the refill.
            state_q      <= FILL;
            cur_delay_q  <= load_delay_d;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_frame_q <= 1'b0;
            dout_valid_q <= 1'b0;
            cfg_busy_q   <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_q == cur_delay_q) begin
                        // D fresh samples are in the line; the oldest is now due.
                        state_q                <= RUN;
                        {dout_q, dout_frame_q} <= mem_q[rd_addr_d];
                        dout_valid_q           <= 1'b1;
                        cfg_busy_q             <= 1'b0;
                    end else begin
                        if (fill_q != '1) begin
                            fill_q <= fill_q + AW'(1);
                        end
                        dout_q       <= '0;
                        dout_frame_q <= 1'b0;
                        dout_valid_q <= 1'b0;
                        cfg_busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    {dout_q, dout_frame_q} <= mem_q[rd_addr_d];
                    dout_valid_q           <= 1'b1;
                    cfg_busy_q             <= 1'b0;
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign cfg_busy   = cfg_busy_q;
    assign cur_delay  = cur_delay_q;
    assign dout       = dout_q;
    assign dout_frame = dout_frame_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_prog_delay_rg.sv
// Directed bench for prog_delay_rg at default parameters (W=6, DMAX=128, DDEF=100).
// Every applied sample is recorded by edge number; the expected output at edge k
// is the sample recorded at edge k-D once D fresh samples follow the last load/reset.
module tb_prog_delay_rg;

    localparam int W    = 6;
    localparam int DMAX = 128;
    localparam int DDEF = 100;
    localparam int AW   = $clog2(DMAX + 1);

    logic          clk;
    logic          reset;
    logic [W-1:0]  din;
    logic          din_frame;
    logic [AW-1:0] cfg_delay;
    logic          cfg_load;
    logic          cfg_busy;
    logic [AW-1:0] cur_delay;
    logic [W-1:0]  dout;
    logic          dout_frame;
    logic          dout_valid;

    prog_delay_rg #(.W(W), .DMAX(DMAX), .DDEF(DDEF)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_frame  (din_frame),
        .cfg_delay  (cfg_delay),
        .cfg_load   (cfg_load),
        .cfg_busy   (cfg_busy),
        .cur_delay  (cur_delay),
        .dout       (dout),
        .dout_frame (dout_frame),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic [W:0] hist [0:4095];
    int         m_d         = DDEF;
    int         m_start     = 0;
    int         rise_cyc    = -1;
    int         load_cyc    = 0;
    int         reset_cyc   = 0;
    int         l2          = 0;
    logic       prev_valid  = 1'b0;
    bit         rnd_mode    = 1'b0;

    function automatic int model_clamp(input int r);
        if (r == 0) return 1;
        if (r > DMAX) return DMAX;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge: record the applied sample, update the reference, check outputs.
    task automatic tick();
        logic       exp_valid;
        logic [W:0] exp_data;
        @(posedge clk);
        cyc++;
        hist[cyc] = {din, din_frame};
        if (reset) begin
            m_d       = DDEF;
            m_start   = cyc + 1;
            reset_cyc = cyc;
        end else if (cfg_load) begin
            m_d      = model_clamp(int'(cfg_delay));
            m_start  = cyc + 1;
            load_cyc = cyc;
        end
        #1;
        exp_valid = (cyc >= m_start + m_d);
        exp_data  = exp_valid ? hist[cyc - m_d] : '0;
        check("valid", 32'(dout_valid), 32'(exp_valid));
        check("busy", 32'(cfg_busy), 32'(!exp_valid));
        check("cur_delay", 32'(cur_delay), 32'(m_d));
        check("data", 32'({dout, dout_frame}), 32'(exp_data));
        if (dout_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = dout_valid;
        // Next stimulus
        cfg_load = 1'b0;
        if (rnd_mode) begin
            din       = W'($urandom);
            din_frame = 1'($urandom);
        end else begin
            din       = din + W'(1);
            din_frame = din[0] ^ din[3];
        end
    endtask

    initial begin
        reset     = 1'b1;
        cfg_load  = 1'b1;
        cfg_delay = AW'(3);
        din       = '0;
        din_frame = 1'b0;

        // Reset with a simultaneous load: load discarded
        tick();
        tick();
        tick();
        check("rst_cur_delay", 32'(cur_delay), 32'd100);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd1);
        reset = 1'b0;

        // Default delay, counter data
        repeat (150) tick();
        check("first_valid_after_reset", 32'(rise_cyc - reset_cyc), 32'd101);

        // Load 5 while running
        cfg_delay = AW'(5);
        cfg_load  = 1'b1;
        tick();
        check("load5_valid_drop", 32'(dout_valid), 32'd0);
        repeat (20) tick();
        check("load5_latency", 32'(rise_cyc - load_cyc), 32'd6);

        // Clamp 0 -> 1
        cfg_delay = AW'(0);
        cfg_load  = 1'b1;
        tick();
        check("clamp0_cur", 32'(cur_delay), 32'd1);
        repeat (10) tick();
        check("clamp0_latency", 32'(rise_cyc - load_cyc), 32'd2);

        // Clamp 200 -> 128
        cfg_delay = AW'(200);
        cfg_load  = 1'b1;
        tick();
        check("clamp200_cur", 32'(cur_delay), 32'd128);
        repeat (140) tick();
        check("clamp200_latency", 32'(rise_cyc - load_cyc), 32'd129);

        // Load 50, then load 7 three cycles later: last load wins
        cfg_delay = AW'(50);
        cfg_load  = 1'b1;
        tick();
        tick();
        tick();
        cfg_delay = AW'(7);
        cfg_load  = 1'b1;
        tick();
        l2 = cyc;
        repeat (7) tick();
        check("restart_not_yet", 32'(dout_valid), 32'd0);
        tick();
        check("restart_first_valid", 32'(dout_valid), 32'd1);
        check("restart_first_sample", 32'({dout, dout_frame}), 32'(hist[l2 + 1]));
        check("restart_latency", 32'(rise_cyc - l2), 32'd8);
        repeat (10) tick();

        // Same delay reloaded still refills
        cfg_delay = AW'(7);
        cfg_load  = 1'b1;
        tick();
        check("same_delay_refill", 32'(cfg_busy), 32'd1);
        repeat (10) tick();

        // Maximum delay, random data, several pointer wraps
        rnd_mode  = 1'b1;
        cfg_delay = AW'(128);
        cfg_load  = 1'b1;
        tick();
        repeat (3 * DMAX + 140) tick();
        check("dmax_latency", 32'(rise_cyc - load_cyc), 32'd129);

        // Reset mid-fill together with a load
        cfg_delay = AW'(20);
        cfg_load  = 1'b1;
        tick();
        repeat (5) tick();
        reset     = 1'b1;
        cfg_load  = 1'b1;
        cfg_delay = AW'(3);
        tick();
        check("midfill_rst_cur", 32'(cur_delay), 32'd100);
        check("midfill_rst_dout", 32'(dout), 32'd0);
        check("midfill_rst_frame", 32'(dout_frame), 32'd0);
        check("midfill_rst_valid", 32'(dout_valid), 32'd0);
        check("midfill_rst_busy", 32'(cfg_busy), 32'd1);
        reset = 1'b0;
        repeat (110) tick();
        check("midfill_rst_latency", 32'(rise_cyc - reset_cyc), 32'd101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
